// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. It issues a one-cycle start carrying the winner's byte, acks the
// winner once the transmitter reports busy, and keeps off the transmitter
// until the two-cycle done pulse has ended. A watchdog abandons a start that
// the transmitter never takes, and the aborted requester drops to lowest
// priority for the next round.
module uart_tx_arbiter #(
  parameter int  NUM_REQ     = 4,
  parameter int  ACK_TIMEOUT = 16,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [IDX_W-1:0]     owner,
  output logic                 active,
  output logic                 timeout_err,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        count_r;
  logic [IDX_W-1:0]        last_r;
  logic [IDX_W-1:0]        owner_r;
  logic [NUM_REQ-1:0]      ack_r;
  logic                    active_r;
  logic                    timeout_err_r;
  logic                    tx_start_r;
  logic [7:0]              tx_data_r;

  logic [NUM_REQ-1:0][7:0] req_bytes_s;
  logic                    sel_valid_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic [IDX_W-1:0]        cand_s;
  logic                    hit_s;

  // Index reached by stepping 'off' positions past 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int off);
    rr_index = IDX_W'((int'(base) + off) % NUM_REQ);
  endfunction

  assign req_bytes_s = req_data;

  // Round-robin pick: first pending request scanning from last_r+1 upward.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
    hit_s       = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s      = rr_index(last_r, off);
      hit_s       = !sel_valid_s && req[cand_s];
      sel_idx_s   = hit_s ? cand_s : sel_idx_s;
      sel_valid_s = sel_valid_s | hit_s;
    end
  end

  // Arbitration FSM; every output is a register written only here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      count_r       <= {CNT_W{1'b0}};
      last_r        <= IDX_W'(NUM_REQ - 1);
      owner_r       <= {IDX_W{1'b0}};
      ack_r         <= {NUM_REQ{1'b0}};
      active_r      <= 1'b0;
      timeout_err_r <= 1'b0;
      tx_start_r    <= 1'b0;
      tx_data_r     <= 8'h00;
    end else begin
      tx_start_r    <= 1'b0;
      ack_r         <= {NUM_REQ{1'b0}};
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Busy/done also guard against a transmitter still mid-frame
          // after this block alone was reset.
          if (sel_valid_s && !tx_busy && !tx_done) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= req_bytes_s[sel_idx_s];
            owner_r    <= sel_idx_s;
            last_r     <= sel_idx_s;
            active_r   <= 1'b1;
            count_r    <= {CNT_W{1'b0}};
            state_r    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          count_r <= count_r + CNT_W'(1);
          if (tx_busy) begin
            ack_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
            state_r <= WAIT_DONE;
          end else if (count_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            // last_r keeps the aborted index so it is served last next round.
            timeout_err_r <= 1'b1;
            active_r      <= 1'b0;
            state_r       <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          // Hold until the second done cycle is over so a new start never
          // overlaps it.
          if (!tx_done) begin
            active_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          active_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_r;
  assign owner       = owner_r;
  assign active      = active_r;
  assign timeout_err = timeout_err_r;
  assign tx_data     = tx_data_r;
  assign tx_start    = tx_start_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a behavioural UART transmitter, a table of
// directed grants, hand-written watchdog and reset-mid-frame sequences, and a
// randomized run checked against a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int BIT_CLKS    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        active;
  logic        timeout_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy  = 1'b0;
  logic        tx_done  = 1'b0;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .owner(owner), .active(active), .timeout_err(timeout_err),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Behavioural transmitter (no reset, like the real one): start bit, 8 data
  // bits LSB first, stop bit, then a 2-cycle done pulse.
  logic       xmit_dead = 1'b0;
  logic       serial    = 1'b1;
  logic [9:0] frame_r   = 10'h3FF;
  int         bit_idx   = 0;
  int         phase     = 0;
  int         done_cnt  = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_bytes[$];
  logic       line_q[$];

  always @(posedge clk) begin
    if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) tx_done <= 1'b0;
    end
    if (!tx_busy) begin
      if (tx_start === 1'b1 && !xmit_dead) begin
        tx_busy <= 1'b1;
        frame_r <= {1'b1, tx_data, 1'b0};
        bit_idx <= 0;
        phase   <= 0;
        serial  <= 1'b0;
        line_q.push_back(1'b0);
      end
    end else if (phase == BIT_CLKS - 1) begin
      phase <= 0;
      if (bit_idx == 9) begin
        tx_busy  <= 1'b0;
        tx_done  <= 1'b1;
        done_cnt <= 2;
        serial   <= 1'b1;
        sent_q.push_back(frame_r[8:1]);
      end else begin
        bit_idx <= bit_idx + 1;
        serial  <= frame_r[bit_idx + 1];
        line_q.push_back(frame_r[bit_idx + 1]);
      end
    end else begin
      phase <= phase + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return 8'(d >> (8 * i));
  endfunction

  function automatic logic req_bit(input logic [3:0] r, input int i);
    return ((r >> i) & 4'd1) != 4'd0;
  endfunction

  // Reference round-robin: first set bit scanning last+1, last+2, ... mod 4.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    int pick = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx = (last + k) % NUM_REQ;
      if (pick < 0 && req_bit(r, idx)) pick = idx;
    end
    return pick;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({tag, " rst tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, " rst tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, " rst ack"}, 32'(ack), 32'd0);
    chk({tag, " rst owner"}, 32'(owner), 32'd0);
    chk({tag, " rst active"}, 32'(active), 32'd0);
    chk({tag, " rst timeout_err"}, 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int exp_owner, input bit push, input string tag,
                            output bit seen);
    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      seen = (tx_start === 1'b1);
    end
    chk({tag, " grant seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " owner"}, 32'(owner), 32'(exp_owner));
      chk({tag, " tx_data"}, 32'(tx_data), 32'(byte_of(req_data, exp_owner)));
      chk({tag, " active"}, 32'(active), 32'd1);
      if (push) exp_bytes.push_back(byte_of(req_data, exp_owner));
    end
  endtask

  task automatic finish_frame(input int exp_owner, input string tag);
    bit bad = 1'b0;
    @(negedge clk);
    chk({tag, " start one cycle"}, 32'(tx_start), 32'd0);
    chk({tag, " ack not early"}, 32'(ack), 32'd0);
    @(negedge clk);
    chk({tag, " ack"}, 32'(ack), 32'(1 << exp_owner));
    req = req & ~4'(1 << exp_owner);
    for (int w = 0; w < 200 && active === 1'b1; w++) begin
      @(negedge clk);
      if (ack !== 4'd0 || tx_start !== 1'b0) bad = 1'b1;
    end
    chk({tag, " single ack no start"}, 32'(bad), 32'd0);
    chk({tag, " active fell"}, 32'(active), 32'd0);
    chk({tag, " done low at fall"}, 32'(tx_done), 32'd0);
  endtask

  task automatic serve(input int exp_owner, input string tag);
    bit seen;
    wait_grant(exp_owner, 1'b1, tag, seen);
    if (seen) finish_frame(exp_owner, tag);
  endtask

  task automatic check_sb(input string tag);
    chk({tag, " byte count"}, 32'(sent_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < sent_q.size(); i++)
      chk({tag, " sent byte"}, 32'(sent_q[i]), 32'(exp_bytes[i]));
    sent_q.delete();
    exp_bytes.delete();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_owner;
  } vec_t;

  vec_t       vecs[14];
  logic [9:0] exp_line;
  bit         seen;
  bit         bad;
  bit         early;
  bit         late;
  bit         blocked_p;

  initial begin
    // Grant sequence starting from reset (last = 3).
    vecs[0]  = '{4'b0100, 32'h00A50000, 2};
    vecs[1]  = '{4'b1111, 32'h13121110, 3};
    vecs[2]  = '{4'b1111, 32'h13121110, 0};
    vecs[3]  = '{4'b1111, 32'h13121110, 1};
    vecs[4]  = '{4'b1111, 32'h13121110, 2};
    vecs[5]  = '{4'b1111, 32'h13121110, 3};
    vecs[6]  = '{4'b1111, 32'h13121110, 0};
    vecs[7]  = '{4'b1010, 32'h44332211, 1};
    vecs[8]  = '{4'b1010, 32'h44332211, 3};
    vecs[9]  = '{4'b0011, 32'h00005A66, 0};
    vecs[10] = '{4'b0011, 32'h00005A66, 1};
    vecs[11] = '{4'b1000, 32'hC3000000, 3};
    vecs[12] = '{4'b1010, 32'hC3009600, 1};
    vecs[13] = '{4'b1010, 32'hC3009600, 3};

    rst_n    = 1'b0;
    req      = 4'd0;
    req_data = 32'd0;

    // ---------------- table-driven grants ----------------
    do_reset("init");
    line_q.delete();
    for (int v = 0; v < 14; v++) begin
      req      = vecs[v].req;
      req_data = vecs[v].data;
      serve(vecs[v].exp_owner, $sformatf("vec%0d", v));
    end
    req = 4'd0;
    exp_line = 10'b1101001010;
    chk("A5 line length", 32'(line_q.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < line_q.size(); i++)
      chk($sformatf("A5 line bit%0d", i), 32'(line_q[i]), 32'(exp_line[i]));
    check_sb("table");

    // ---------------- watchdog ----------------
    do_reset("wd");
    xmit_dead = 1'b1;
    req_data  = 32'h00334455;
    req       = 4'b0111;
    wait_grant(0, 1'b0, "wd abort", seen);
    bad = 1'b0;
    for (int k = 1; k <= ACK_TIMEOUT && seen; k++) begin
      @(negedge clk);
      if (ack !== 4'd0) bad = 1'b1;
      if (k < ACK_TIMEOUT && timeout_err !== 1'b0) bad = 1'b1;
      if (k == ACK_TIMEOUT) begin
        chk("wd timeout_err", 32'(timeout_err), 32'd1);
        chk("wd active low", 32'(active), 32'd0);
        xmit_dead = 1'b0;
        req       = 4'b0000;
      end
    end
    chk("wd no ack or early timeout", 32'(bad), 32'd0);
    @(negedge clk);
    chk("wd timeout one cycle", 32'(timeout_err), 32'd0);
    chk("wd no start without req", 32'(tx_start), 32'd0);
    req = 4'b0111;
    serve(1, "wd next1");
    serve(2, "wd next2");
    serve(0, "wd regrant0");
    check_sb("wd");

    // ---------------- reset mid-frame ----------------
    do_reset("rmf pre");
    req_data = 32'h0077003C;
    req      = 4'b0001;
    wait_grant(0, 1'b1, "rmf first", seen);
    @(negedge clk);
    @(negedge clk);
    chk("rmf first ack", 32'(ack), 32'd1);
    req = 4'b0100;
    repeat (12) @(negedge clk);
    do_reset("rmf");
    blocked_p = tx_busy | tx_done;
    seen  = 1'b0;
    early = 1'b0;
    late  = 1'b0;
    for (int w = 0; w < 300 && !seen; w++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        if (blocked_p) early = 1'b1;
      end else if (!blocked_p) begin
        late = 1'b1;
      end
      blocked_p = tx_busy | tx_done;
    end
    chk("rmf regrant seen", 32'(seen), 32'd1);
    chk("rmf no start while tx busy/done", 32'(early), 32'd0);
    chk("rmf start once tx idle", 32'(late), 32'd0);
    if (seen) begin
      chk("rmf owner", 32'(owner), 32'd2);
      chk("rmf tx_data", 32'(tx_data), 32'h77);
      exp_bytes.push_back(8'h77);
      finish_frame(2, "rmf");
    end
    check_sb("rmf");

    // ---------------- randomized against reference model ----------------
    begin
      int   last_m  = NUM_REQ - 1;
      int   ack_cd  = 0;
      int   ack_own = 0;
      int   exp_o;
      logic active_p, busy_p, done_p, done_pp, exp_start;
      logic [3:0] exp_ack;
      req = 4'd0;
      do_reset("rand");
      req_data = $urandom;
      active_p = active;
      busy_p   = tx_busy;
      done_p   = tx_done;
      done_pp  = tx_done;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        exp_start = !active_p && (req != 4'd0) && !busy_p && !done_p;
        chk("rand tx_start", 32'(tx_start), 32'(exp_start));
        exp_ack = 4'd0;
        if (ack_cd > 0) begin
          ack_cd--;
          if (ack_cd == 0) exp_ack = 4'(1 << ack_own);
        end
        if (tx_start === 1'b1) begin
          exp_o = rr_pick(req, last_m);
          chk("rand owner", 32'(owner), 32'(exp_o));
          chk("rand tx_data", 32'(tx_data), 32'(byte_of(req_data, exp_o)));
          exp_bytes.push_back(byte_of(req_data, exp_o));
          last_m  = exp_o;
          ack_own = exp_o;
          ack_cd  = 2;
        end
        chk("rand ack", 32'(ack), 32'(exp_ack));
        chk("rand timeout_err", 32'(timeout_err), 32'd0);
        if (!active_p && active === 1'b1)
          chk("rand active rise with start", 32'(tx_start), 32'd1);
        if (active_p && active === 1'b0)
          chk("rand active fall after done", 32'({done_pp, done_p}), 32'd2);
        done_pp  = done_p;
        done_p   = tx_done;
        busy_p   = tx_busy;
        active_p = active;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_bit(ack, i)) begin
            if ($urandom_range(1, 0) == 0) begin
              req = req & ~4'(1 << i);
            end else begin
              req_data = (req_data & ~(32'hFF << (8 * i))) | (32'($urandom_range(255, 0)) << (8 * i));
            end
          end else if (!req_bit(req, i) && $urandom_range(7, 0) == 0) begin
            req      = req | 4'(1 << i);
            req_data = (req_data & ~(32'hFF << (8 * i))) | (32'($urandom_range(255, 0)) << (8 * i));
          end
        end
      end
      req = 4'd0;
      bad = 1'b1;
      for (int w = 0; w < 300 && bad; w++) begin
        @(negedge clk);
        bad = active | tx_busy | tx_done;
      end
      chk("rand drained", 32'(bad), 32'd0);
      check_sb("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
